// File: rtl/dsp_mode_controller_pkg.sv
// dsp_mode_controller_pkg: mode encodings, FSM state codes and gain constants
package dsp_mode_controller_pkg;
   localparam int GAIN_W = 9;
   localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;
   localparam logic [1:0] MODE_BYPASS  = 2'b00;
   localparam logic [1:0] MODE_FIR     = 2'b01;
   localparam logic [1:0] MODE_ECHO    = 2'b10;
   localparam logic [1:0] MODE_ILLEGAL = 2'b11;
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_FADE_OUT = 3'd1;
   localparam state_t ST_SWITCH   = 3'd2;
   localparam state_t ST_SETTLE   = 3'd3;
   localparam state_t ST_FADE_IN  = 3'd4;
endpackage

// File: rtl/dsp_mode_controller_gain_scaler.sv
// gain_scaler: registered signed 16-bit sample times unsigned 9-bit gain, shifted right 8
module gain_scaler
   import dsp_mode_controller_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic signed [15:0]       i_sample,
   input  logic [GAIN_W-1:0]        i_gain,
   output logic signed [15:0]       o_sample
);
   logic signed [24:0] w_prod;
   logic signed [15:0] r_sample;
   assign w_prod   = 25'(i_sample) * 25'($signed({1'b0, i_gain}));
   assign o_sample = r_sample;
   // gain <= unity keeps the magnitude within the input range, so plain truncation is safe
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sample <= '0;
      else r_sample <= 16'(w_prod >>> 8);
   end
endmodule

// File: rtl/dsp_mode_controller.sv
// dsp_mode_controller: click-free DSP mode switching via fade-out, switch, settle and fade-in
module dsp_mode_controller
   import dsp_mode_controller_pkg::*;
#(
   parameter int GAIN_STEP      = 8,
   parameter int SETTLE_SAMPLES = 32
) (
   input  logic                     sample_clock,
   input  logic                     reset,
   input  logic [1:0]               mode_req,
   input  logic                     mode_req_valid,
   output logic                     mode_req_ready,
   output logic [1:0]               selector,
   input  logic signed [15:0]       dsp_sample,
   output logic signed [15:0]       out_sample,
   output logic [GAIN_W-1:0]        gain,
   output logic                     busy,
   output logic                     mode_done,
   output logic                     mode_err
);
   localparam logic [GAIN_W-1:0] STEP        = GAIN_W'(GAIN_STEP);
   localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);
   state_t              r_state;
   logic [1:0]          r_selector;
   logic [1:0]          r_mode;
   logic [GAIN_W-1:0]   r_gain;
   logic [7:0]          r_cnt;
   logic                r_done;
   logic                r_err;
   logic [GAIN_W-1:0]   w_gain_dn;
   logic [GAIN_W-1:0]   w_gain_up;
   assign w_gain_dn      = (r_gain > STEP) ? r_gain - STEP : '0;
   assign w_gain_up      = (r_gain >= GAIN_UNITY - STEP) ? GAIN_UNITY : r_gain + STEP;
   assign mode_req_ready = (r_state == ST_IDLE);
   assign busy           = (r_state != ST_IDLE);
   assign selector       = r_selector;
   assign gain           = r_gain;
   assign mode_done      = r_done;
   assign mode_err       = r_err;
   // mode-switch sequencer; selector only moves in SWITCH, when gain is already zero
   always_ff @(posedge sample_clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_selector <= MODE_BYPASS;
         r_mode     <= MODE_BYPASS;
         r_gain     <= GAIN_UNITY;
         r_cnt      <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: if (mode_req_valid) begin
               if (mode_req == MODE_ILLEGAL) r_err <= 1'b1;
               else if (mode_req == r_selector) r_done <= 1'b1;
               else begin
                  r_mode  <= mode_req;
                  r_state <= ST_FADE_OUT;
               end
            end
            ST_FADE_OUT: begin
               r_gain <= w_gain_dn;
               if (w_gain_dn == '0) r_state <= ST_SWITCH;
            end
            ST_SWITCH: begin
               r_selector <= r_mode;
               r_cnt      <= '0;
               r_state    <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_cnt == SETTLE_LAST) r_state <= ST_FADE_IN;
               else r_cnt <= r_cnt + 8'd1;
            end
            ST_FADE_IN: begin
               r_gain <= w_gain_up;
               if (w_gain_up == GAIN_UNITY) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
   gain_scaler u_scaler (
      .i_clk    (sample_clock),
      .i_rst_n  (reset),
      .i_sample (dsp_sample),
      .i_gain   (r_gain),
      .o_sample (out_sample)
   );
endmodule

// File: tb/tb_dsp_mode_controller.sv
// tb_dsp_mode_controller: random and directed stimulus against a per-transaction timeline model
module tb_dsp_mode_controller;
   localparam int STEP   = 8;
   localparam int SETTLE = 32;
   localparam int NFADE  = (256 + STEP - 1) / STEP;
   logic              sample_clock = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        mode_req = 2'b00;
   logic              mode_req_valid = 1'b0;
   logic              mode_req_ready;
   logic [1:0]        selector;
   logic signed [15:0] dsp_sample = '0;
   logic signed [15:0] out_sample;
   logic [8:0]        gain;
   logic              busy;
   logic              mode_done;
   logic              mode_err;
   logic signed [15:0] gs_sample = '0;
   logic signed [15:0] gs_out;
   logic [8:0]        gs_gain = '0;
   int n_checks = 0;
   int n_fail   = 0;
   typedef struct {int gain; int sel; bit busy; bit done;} ent_t;
   ent_t q[$];
   int exp_gain = 256;
   int exp_sel  = 0;
   int exp_out  = 0;
   bit exp_busy = 0;
   bit exp_done = 0;
   bit exp_err  = 0;
   bit accepted = 0;

   dsp_mode_controller #(.GAIN_STEP(STEP), .SETTLE_SAMPLES(SETTLE)) dut (
      .sample_clock   (sample_clock),
      .reset          (reset),
      .mode_req       (mode_req),
      .mode_req_valid (mode_req_valid),
      .mode_req_ready (mode_req_ready),
      .selector       (selector),
      .dsp_sample     (dsp_sample),
      .out_sample     (out_sample),
      .gain           (gain),
      .busy           (busy),
      .mode_done      (mode_done),
      .mode_err       (mode_err)
   );

   gain_scaler u_gs (
      .i_clk    (sample_clock),
      .i_rst_n  (reset),
      .i_sample (gs_sample),
      .i_gain   (gs_gain),
      .o_sample (gs_out)
   );

   always #5 sample_clock = ~sample_clock;

   task automatic chk(input string tag, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, want, $time);
      end
   endtask

   // full expected trajectory of one legal switch, one entry per sample after acceptance
   task automatic push_txn(input int old_sel, input int new_sel);
      for (int k = 0; k <= NFADE; k++)
         q.push_back(ent_t'{(256 - k * STEP < 0) ? 0 : 256 - k * STEP, old_sel, 1'b1, 1'b0});
      q.push_back(ent_t'{0, new_sel, 1'b1, 1'b0});
      for (int j = 1; j <= SETTLE; j++) q.push_back(ent_t'{0, new_sel, 1'b1, 1'b0});
      for (int i = 1; i <= NFADE; i++)
         q.push_back(ent_t'{(i * STEP > 256) ? 256 : i * STEP, new_sel, i < NFADE, i == NFADE});
   endtask

   task automatic check_all();
      chk("gain", int'(gain), exp_gain);
      chk("selector", int'(selector), exp_sel);
      chk("busy", int'(busy), int'(exp_busy));
      chk("ready", int'(mode_req_ready), int'(!exp_busy));
      chk("mode_done", int'(mode_done), int'(exp_done));
      chk("mode_err", int'(mode_err), int'(exp_err));
      chk("out_sample", int'(out_sample), exp_out);
   endtask

   task automatic step();
      int s, g;
      bit v;
      int m;
      ent_t e;
      case ($urandom_range(0, 5))
         0: dsp_sample = 16'sh8000;
         1: dsp_sample = 16'sh7fff;
         2: dsp_sample = 16'sh0001;
         3: dsp_sample = 16'shffff;
         default: dsp_sample = 16'($urandom);
      endcase
      s = int'(dsp_sample);
      g = exp_gain;
      v = mode_req_valid;
      m = int'(mode_req);
      @(posedge sample_clock);
      #1;
      exp_out  = (s * g) >>> 8;
      accepted = 0;
      exp_done = 0;
      exp_err  = 0;
      if (q.size() > 0) begin
         e = q.pop_front();
         exp_gain = e.gain; exp_sel = e.sel; exp_busy = e.busy; exp_done = e.done;
      end else if (v) begin
         accepted = 1;
         if (m == 3) exp_err = 1;
         else if (m == exp_sel) exp_done = 1;
         else begin
            push_txn(exp_sel, m);
            e = q.pop_front();
            exp_gain = e.gain; exp_sel = e.sel; exp_busy = e.busy; exp_done = e.done;
         end
      end
      check_all();
   endtask

   task automatic req(input logic [1:0] m);
      int n = 0;
      mode_req_valid = 1'b1;
      mode_req = m;
      do begin step(); n++; end while (!accepted && n < 400);
      if (!accepted) chk("req_timeout", 0, 1);
      mode_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_busy && n < 400) begin step(); n++; end
   endtask

   initial begin
      int n;
      bit d;
      logic signed [15:0] gs_in [4] = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh0001};
      logic [8:0] gs_g [4] = '{9'd256, 9'd128, 9'd1, 9'd128};
      int gs_exp [4] = '{-32768, -16384, -128, 0};
      #2 reset = 1'b0;
      #1 check_all();
      @(posedge sample_clock);
      #1 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         gs_sample = gs_in[i];
         gs_gain = gs_g[i];
         @(posedge sample_clock);
         #1 chk($sformatf("scaler_%0d", i), int'(gs_out), gs_exp[i]);
      end
      req(2'b11);
      step();
      req(2'b00);
      step();
      req(2'b01);
      n = 0;
      while (!mode_done && n < 300) begin step(); n++; end
      chk("fir_len", n, 2 * NFADE + SETTLE + 1);
      req(2'b10);
      n = 0;
      while (!(exp_sel == 2 && exp_gain > 0) && n < 300) begin step(); n++; end
      mode_req_valid = 1'b1;
      mode_req = 2'b00;
      n = 0;
      d = 0;
      accepted = 0;
      while (!accepted && n < 300) begin d = mode_done; step(); n++; end
      chk("held_after_done", int'(d), 1);
      mode_req_valid = 1'b0;
      wait_idle();
      req(2'b10);
      wait_idle();
      req(2'b10);
      req(2'b01);
      n = 0;
      while (exp_sel != 1 && n < 300) begin step(); n++; end
      repeat (5) step();
      #3 reset = 1'b0;
      q.delete();
      exp_gain = 256; exp_sel = 0; exp_out = 0;
      exp_busy = 0; exp_done = 0; exp_err = 0;
      #1 check_all();
      @(posedge sample_clock);
      #1 check_all();
      reset = 1'b1;
      repeat (10) step();
      for (int c = 0; c < 2000; c++) begin
         if (!mode_req_valid && $urandom_range(0, 7) == 0) begin
            mode_req_valid = 1'b1;
            mode_req = 2'($urandom_range(0, 3));
         end
         step();
         if (accepted) mode_req_valid = 1'b0;
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
